// File: rtl/tdc_hit_buffer_if.sv
// tdc_hit_buffer_if
//   Bundles the TDC hit input, readout handshake and FIFO status of the
//   hit buffer. The master modport is the side that drives START/hits and
//   read requests. The slave modport is the buffer itself.
//   START, TIME_IN, VALID_IN : acquisition start level, TDC result, hit strobe
//   RD_EN, OVF_CLR           : read request, overflow clear
//   DOUT, DOUT_VALID         : read data and its one-cycle valid
//   EMPTY, FULL, OVERFLOW    : FIFO status, sticky frame-rejected flag
//   WORD_COUNT               : words currently held
interface tdc_hit_buffer_if #(
   parameter int DEPTH_LOG2 = 6
) ();
   logic                  START;
   logic [7:0]            TIME_IN;
   logic                  VALID_IN;
   logic                  RD_EN;
   logic                  OVF_CLR;
   logic [15:0]           DOUT;
   logic                  DOUT_VALID;
   logic                  EMPTY;
   logic                  FULL;
   logic                  OVERFLOW;
   logic [DEPTH_LOG2:0]   WORD_COUNT;

   modport master (
      output START, TIME_IN, VALID_IN, RD_EN, OVF_CLR,
      input  DOUT, DOUT_VALID, EMPTY, FULL, OVERFLOW, WORD_COUNT
   );

   modport slave (
      input  START, TIME_IN, VALID_IN, RD_EN, OVF_CLR,
      output DOUT, DOUT_VALID, EMPTY, FULL, OVERFLOW, WORD_COUNT
   );
endinterface

// File: rtl/tdc_hit_buffer.sv
// tdc_hit_buffer
//   Frames each START-opened acquisition window into a header word, up to
//   MAX_HITS time words and a trailer word, and stores them in a FIFO that
//   the readout drains with a read-enable / one-cycle-latency handshake.
//   CLK  : system clock, rising edge
//   RSTb : asynchronous active-low reset
//   bus  : tdc_hit_buffer_if slave (hit input, readout, status)
module tdc_hit_buffer #(
   parameter int DEPTH_LOG2 = 6,
   parameter int WINDOW     = 200,
   parameter int MAX_HITS   = 15
) (
   input  logic CLK,
   input  logic RSTb,
   tdc_hit_buffer_if.slave bus
);
   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam int RESERVE = MAX_HITS + 2;
   localparam int WIN_M1  = WINDOW - 1;
   localparam logic [DEPTH_LOG2:0] DEPTH_W = DEPTH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0] RES_W   = RESERVE[DEPTH_LOG2:0];
   localparam logic [4:0]          MAX_H   = MAX_HITS[4:0];
   localparam logic [15:0]         WLAST   = WIN_M1[15:0];

   typedef enum logic [1:0] {IDLE, ARMED, CLOSE} state_t;

   state_t                  state_q, state_d;
   logic                    start_q;
   logic [11:0]             evt_q, evt_d;
   logic [15:0]             wcnt_q, wcnt_d;
   logic [4:0]              hcnt_q, hcnt_d;
   logic                    trunc_q, trunc_d;
   logic                    reject;
   logic                    wr_en;
   logic [15:0]             wr_data;

   logic [15:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]     cnt_q, cnt_d;
   logic                    empty_q, full_q, ovf_q, dv_q;
   logic [15:0]             dout_q;

   logic start_edge, has_room, rd_fire;

   assign start_edge = bus.START & ~start_q;
   // A frame is only opened if its worst case (header + MAX_HITS + trailer)
   // already fits, so writes inside an accepted frame never need a full check.
   assign has_room   = (DEPTH_W - cnt_q) >= RES_W;
   assign rd_fire    = bus.RD_EN & ~empty_q;

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         evt_q   <= '0;
         wcnt_q  <= '0;
         hcnt_q  <= '0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= bus.START;
         evt_q   <= evt_d;
         wcnt_q  <= wcnt_d;
         hcnt_q  <= hcnt_d;
         trunc_q <= trunc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      evt_d   = evt_q;
      wcnt_d  = wcnt_q;
      hcnt_d  = hcnt_q;
      trunc_d = trunc_q;
      reject  = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      case (state_q)
         IDLE: begin
            if (start_edge) begin
               // Rejected windows still consume an event number.
               evt_d = evt_q + 12'd1;
               if (has_room) begin
                  wr_en   = 1'b1;
                  wr_data = {2'b10, 2'b00, evt_q};
                  state_d = ARMED;
                  wcnt_d  = '0;
                  hcnt_d  = '0;
                  trunc_d = 1'b0;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         ARMED: begin
            wcnt_d = wcnt_q + 16'd1;
            if (bus.VALID_IN) begin
               if (hcnt_q < MAX_H) begin
                  wr_en   = 1'b1;
                  wr_data = {2'b00, hcnt_q[3:0], 2'b00, bus.TIME_IN};
                  hcnt_d  = hcnt_q + 5'd1;
               end else begin
                  trunc_d = 1'b1;
               end
            end
            if (wcnt_q == WLAST) state_d = CLOSE;
         end
         CLOSE: begin
            // evt_q already advanced past this frame's number at the header.
            wr_en   = 1'b1;
            wr_data = {2'b11, trunc_q, hcnt_q, evt_q[7:0] - 8'd1};
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({wr_en, rd_fire})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            dout_q <= mem[rd_ptr];
         end
         dv_q    <= rd_fire;
         cnt_q   <= cnt_d;
         empty_q <= (cnt_d == '0);
         full_q  <= (cnt_d == DEPTH_W);
         // A rejection in the same cycle as a clear keeps the flag set.
         if (reject)           ovf_q <= 1'b1;
         else if (bus.OVF_CLR) ovf_q <= 1'b0;
      end
   end

   assign bus.DOUT       = dout_q;
   assign bus.DOUT_VALID = dv_q;
   assign bus.EMPTY      = empty_q;
   assign bus.FULL       = full_q;
   assign bus.OVERFLOW   = ovf_q;
   assign bus.WORD_COUNT = cnt_q;
endmodule
